fetch_stage: RTL



---
 rtl/fetch_stage_pkg.sv | 18 +
 rtl/fetch_stage_fd_reg.sv | 15 +
 rtl/fetch_stage.sv | 50 +++++
 3 files changed

// File: rtl/fetch_stage_pkg.sv
// fetch_stage_pkg: shared fetch constants, F/D payload type and fetch-address fault check
package fetch_stage_pkg;
  localparam int WORD_W = 32;
  localparam int IM_WORDS = 4096;
  localparam logic [WORD_W-1:0] PC_RESET = 32'h0000_3000;
  localparam logic [WORD_W-1:0] NOP_WORD = 32'h0000_0000;
  localparam logic [WORD_W:0] PC_END = {1'b0, PC_RESET} + 33'(4 * IM_WORDS);
  typedef struct packed {
    logic [WORD_W-1:0] instr;
    logic [WORD_W-1:0] pc;
    logic              fault;
    logic              valid;
  } fd_t;
  localparam fd_t FD_RESET = '{instr: NOP_WORD, pc: PC_RESET, fault: 1'b0, valid: 1'b0};
  function automatic logic pc_fault(input logic [WORD_W-1:0] pc);
    return (pc[1:0] != 2'b00) || (pc < PC_RESET) || ({1'b0, pc} >= PC_END);
  endfunction
endpackage

// File: rtl/fetch_stage_fd_reg.sv
// fd_reg: F/D pipeline register; clk, rst (sync, active-high), en, d (F side payload), q (D side payload)
module fd_reg
  import fetch_stage_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  fd_t  d,
  output fd_t  q
);
  always_ff @(posedge clk) begin
    if (rst) q <= FD_RESET;
    else if (en) q <= d;
  end
endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: MIPS F stage; clk, reset, stall, redirect_en/redirect_pc in, F_instr from IM; F_pc to IM; D_instr/D_pc/D_pc8/D_valid/D_fault to D; fetch_cnt advance counter
module fetch_stage
  import fetch_stage_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              redirect_en,
  input  logic [WORD_W-1:0] redirect_pc,
  input  logic [WORD_W-1:0] F_instr,
  output logic [WORD_W-1:0] F_pc,
  output logic [WORD_W-1:0] D_instr,
  output logic [WORD_W-1:0] D_pc,
  output logic [WORD_W-1:0] D_pc8,
  output logic              D_valid,
  output logic              D_fault,
  output logic [WORD_W-1:0] fetch_cnt
);
  logic [WORD_W-1:0] pc_q;
  logic [WORD_W-1:0] cnt_q;
  logic              fault;
  fd_t               fd_d;
  fd_t               fd_q;
  assign fault = pc_fault(pc_q);
  assign fd_d = '{instr: fault ? NOP_WORD : F_instr, pc: pc_q, fault: fault, valid: 1'b1};
  // redirect is only honoured on an advancing cycle; D reasserts it after a stall
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q  <= PC_RESET;
      cnt_q <= '0;
    end else if (!stall) begin
      pc_q  <= redirect_en ? redirect_pc : pc_q + 32'd4;
      cnt_q <= cnt_q + 32'd1;
    end
  end
  fd_reg u_fd (
    .clk(clk),
    .rst(reset),
    .en (~stall),
    .d  (fd_d),
    .q  (fd_q)
  );
  assign F_pc      = pc_q;
  assign fetch_cnt = cnt_q;
  assign D_instr   = fd_q.instr;
  assign D_pc      = fd_q.pc;
  assign D_pc8     = fd_q.pc + 32'd8;
  assign D_valid   = fd_q.valid;
  assign D_fault   = fd_q.fault;
endmodule
